// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared FSM encoding and widths for the instruction fetch stage.
package if_stage_pkg;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INSTR_W      = 32;
    localparam int          JUMP_W       = 26;
endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch with redirect draining and a one-entry stall skid buffer.
// Optional perf counters (fetch_cnt, stall_cnt) under `define IF_PERF_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               reloj,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [JUMP_W-1:0]  JUMP_ADDR,
    input  logic [31:0]        PC_4o,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [31:0]        PC_4,
    output logic [INSTR_W-1:0] DO,
    output logic               enableIF,
    output logic               resetIF
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);
    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        tgt_q, tgt_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               redirect;
    logic [31:0]        target;
    logic               unused_pc4o;
`ifdef IF_PERF_CNT_EN
    logic [31:0]        fetch_cnt_q, fetch_cnt_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        buf_d       = buf_q;
        redirect    = branch_taken | jump;
        target      = branch_taken ? branch_target : {PC_4o[31:28], JUMP_ADDR, 2'b00};
        unused_pc4o = ^PC_4o[27:0];
        resetIF     = redirect;
        imem_req    = state_q != HOLD;
        imem_addr   = pc_q;
        PC_4        = pc_q + 32'd4;
        DO          = (state_q == HOLD) ? buf_q : imem_data;
        enableIF    = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (stall) begin
                        buf_d   = imem_data;
                        state_d = HOLD;
                    end else begin
                        enableIF = 1'b1;
                        pc_d     = PC_4;
                    end
                end else if (redirect) begin
                    tgt_d   = target;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The outstanding word is discarded; the youngest redirect decides where to resume.
                if (redirect) tgt_d = target;
                if (imem_ack) begin
                    pc_d    = redirect ? target : tgt_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    enableIF = 1'b1;
                    pc_d     = PC_4;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
`ifdef IF_PERF_CNT_EN
        fetch_cnt_d = fetch_cnt_q + {31'd0, enableIF};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        fetch_cnt   = fetch_cnt_q;
        stall_cnt   = stall_cnt_q;
`endif
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            buf_q       <= '0;
`ifdef IF_PERF_CNT_EN
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_q       <= buf_d;
`ifdef IF_PERF_CNT_EN
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end
endmodule
